// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter: entry layout, grant
// encoding and a helper that turns a destination into a pending-mask bit.
package regfile_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_ALU  = 2'd1,
        WB_SRC_MEM  = 2'd2
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] dest_onehot(input logic [REG_ADDR_W-1:0] d);
        logic [NUM_REGS-1:0] oh;
        oh    = '0;
        oh[d] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory stages, the arbiter and reg_file.
// Handshake: a source transfer happens on a rising edge where valid && ready;
// the source holds dest/data stable while valid is high and ready is low.
interface regfile_wb_arbiter_if;
    import regfile_wb_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_dest;
    logic [XLEN-1:0]       alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic [XLEN-1:0]       mem_data;
    logic                  rf_reg_write;
    logic [REG_ADDR_W-1:0] rf_dest;
    logic [XLEN-1:0]       rf_write_data;
    logic [NUM_REGS-1:0]   pending_mask;

    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready, rf_reg_write, rf_dest, rf_write_data, pending_mask
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready, rf_reg_write, rf_dest, rf_write_data, pending_mask
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO of writeback entries; exposes per-slot valid/dest so
// the parent can build the pending-write mask without reading data.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_i,
    input  wb_entry_t                       push_entry_i,
    input  logic                            pop_i,
    output logic [CNT_W-1:0]                count_o,
    output wb_entry_t                       head_o,
    output logic [DEPTH-1:0]                valid_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_o
);

    wb_entry_t        slot_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;
    logic [PTR_W-1:0] offs;

    assign do_push = push_i && (cnt_q < CNT_W'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (do_push) slot_q[wr_q] <= push_entry_i;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        offs    = '0;
        valid_o = '0;
        dest_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs       = PTR_W'(i) - rd_q;
            valid_o[i] = CNT_W'(offs) < cnt_q;
            dest_o[i]  = slot_q[i].dest;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = slot_q[rd_q];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single reg_file write port between the ALU and load writeback
// queues: mem-first priority, with the ALU forced through after STARVE_LIMIT losses.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus,
    output wb_src_e              dbg_grant_o
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]                       alu_count, mem_count;
    wb_entry_t                              alu_entry, mem_entry, alu_head, mem_head;
    logic [FIFO_DEPTH-1:0]                  alu_vld, mem_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  alu_dests, mem_dests;
    logic                                   alu_rdy, mem_rdy, alu_push, mem_push;
    logic                                   alu_has, mem_has;
    wb_src_e                                grant;
    logic [STARVE_W-1:0]                    starve_q, starve_d;
    logic                                   rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]                  rf_dest_q, rf_dest_d;
    logic [XLEN-1:0]                        rf_data_q, rf_data_d;
    logic [NUM_REGS-1:0]                    mask;

    assign alu_rdy = !rst && (alu_count < CNT_W'(FIFO_DEPTH));
    assign mem_rdy = !rst && (mem_count < CNT_W'(FIFO_DEPTH));

    // Writes to x0 complete the handshake but are dropped here.
    assign alu_push = bus.alu_valid && alu_rdy && (bus.alu_dest != '0);
    assign mem_push = bus.mem_valid && mem_rdy && (bus.mem_dest != '0);

    assign alu_entry.dest = bus.alu_dest;
    assign alu_entry.data = bus.alu_data;
    assign mem_entry.dest = bus.mem_dest;
    assign mem_entry.data = bus.mem_data;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (alu_push),
        .push_entry_i (alu_entry),
        .pop_i        (grant == WB_SRC_ALU),
        .count_o      (alu_count),
        .head_o       (alu_head),
        .valid_o      (alu_vld),
        .dest_o       (alu_dests)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (mem_push),
        .push_entry_i (mem_entry),
        .pop_i        (grant == WB_SRC_MEM),
        .count_o      (mem_count),
        .head_o       (mem_head),
        .valid_o      (mem_vld),
        .dest_o       (mem_dests)
    );

    assign alu_has = alu_count != '0;
    assign mem_has = mem_count != '0;

    always_comb begin
        grant = WB_SRC_NONE;
        if (mem_has && alu_has)
            grant = (starve_q == STARVE_W'(STARVE_LIMIT)) ? WB_SRC_ALU : WB_SRC_MEM;
        else if (mem_has)
            grant = WB_SRC_MEM;
        else if (alu_has)
            grant = WB_SRC_ALU;
    end

    // Counts only losses with an ALU entry waiting; any ALU win or empty queue clears it.
    always_comb begin
        starve_d = '0;
        if (grant == WB_SRC_MEM && alu_has)
            starve_d = (starve_q == STARVE_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_dest_d = '0;
        rf_data_d = '0;
        case (grant)
            WB_SRC_ALU: begin
                rf_we_d   = 1'b1;
                rf_dest_d = alu_head.dest;
                rf_data_d = alu_head.data;
            end
            WB_SRC_MEM: begin
                rf_we_d   = 1'b1;
                rf_dest_d = mem_head.dest;
                rf_data_d = mem_head.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_dest_q <= '0;
            rf_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_dest_q <= rf_dest_d;
            rf_data_q <= rf_data_d;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_vld[i]) mask = mask | dest_onehot(alu_dests[i]);
            if (mem_vld[i]) mask = mask | dest_onehot(mem_dests[i]);
        end
        if (rf_we_q) mask = mask | dest_onehot(rf_dest_q);
        mask[0] = 1'b0;
    end

    assign bus.alu_ready     = alu_rdy;
    assign bus.mem_ready     = mem_rdy;
    assign bus.rf_reg_write  = rf_we_q;
    assign bus.rf_dest       = rf_dest_q;
    assign bus.rf_write_data = rf_data_q;
    assign bus.pending_mask  = mask;
    assign dbg_grant_o       = grant;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a queue-based
// reference model of the writeback arbitration rules.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 3;
    localparam int ENTRY_W      = REG_ADDR_W + XLEN;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    wb_src_e dbg_grant;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_grant_o (dbg_grant)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [ENTRY_W-1:0]    alu_exp_q[$];
    logic [ENTRY_W-1:0]    mem_exp_q[$];
    int                    starve;
    logic                  exp_wr = 1'b0;
    logic [REG_ADDR_W-1:0] exp_dest = '0;
    logic [XLEN-1:0]       exp_data = '0;
    logic                  alu_acc = 1'b0;
    logic                  mem_acc = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int wr_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REGS-1:0] exp_mask();
        logic [NUM_REGS-1:0] m;
        logic [ENTRY_W-1:0]  e;
        m = '0;
        foreach (alu_exp_q[i]) begin
            e = alu_exp_q[i];
            m[e[ENTRY_W-1:XLEN]] = 1'b1;
        end
        foreach (mem_exp_q[i]) begin
            e = mem_exp_q[i];
            m[e[ENTRY_W-1:XLEN]] = 1'b1;
        end
        if (exp_wr) m[exp_dest] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // Advances the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        logic [ENTRY_W-1:0] e;
        bit a_has, m_has, take_alu;
        alu_acc = 1'b0;
        mem_acc = 1'b0;
        if (rst) begin
            alu_exp_q.delete();
            mem_exp_q.delete();
            starve   = 0;
            exp_wr   = 1'b0;
            exp_dest = '0;
            exp_data = '0;
        end else begin
            alu_acc  = bus.alu_valid && (alu_exp_q.size() < FIFO_DEPTH);
            mem_acc  = bus.mem_valid && (mem_exp_q.size() < FIFO_DEPTH);
            a_has    = alu_exp_q.size() != 0;
            m_has    = mem_exp_q.size() != 0;
            take_alu = (a_has && m_has) ? (starve == STARVE_LIMIT) : a_has;
            exp_wr   = a_has || m_has;
            exp_dest = '0;
            exp_data = '0;
            if (exp_wr) begin
                if (take_alu) e = alu_exp_q.pop_front();
                else          e = mem_exp_q.pop_front();
                {exp_dest, exp_data} = e;
            end
            if (a_has && m_has && !take_alu) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
            else                             starve = 0;
            if (alu_acc && bus.alu_dest != '0) begin
                alu_exp_q.push_back({bus.alu_dest, bus.alu_data});
                acc_cnt++;
            end
            if (mem_acc && bus.mem_dest != '0) begin
                mem_exp_q.push_back({bus.mem_dest, bus.mem_data});
                acc_cnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (bus.rf_reg_write === 1'b1) wr_cnt++;
        check("rf_reg_write", bus.rf_reg_write, exp_wr);
        if (exp_wr) begin
            check("rf_dest", bus.rf_dest, exp_dest);
            check("rf_write_data", bus.rf_write_data, exp_data);
        end
        check("pending_mask", bus.pending_mask, exp_mask());
        check("alu_ready", bus.alu_ready, !rst && (alu_exp_q.size() < FIFO_DEPTH));
        check("mem_ready", bus.mem_ready, !rst && (mem_exp_q.size() < FIFO_DEPTH));
    endtask

    task automatic drive_alu(input logic v, input logic [REG_ADDR_W-1:0] d, input logic [XLEN-1:0] x);
        bus.alu_valid = v;
        bus.alu_dest  = d;
        bus.alu_data  = x;
    endtask

    task automatic drive_mem(input logic v, input logic [REG_ADDR_W-1:0] d, input logic [XLEN-1:0] x);
        bus.mem_valid = v;
        bus.mem_dest  = d;
        bus.mem_data  = x;
    endtask

    initial begin
        int src_seq[$];
        int alu_in, alu_out;
        bit bp_exp[5];
        bp_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b0, '0, '0);

        // Reset with a pending ALU request
        rst = 1'b1;
        drive_alu(1'b1, REG_ADDR_W'(7), 32'h1111_1111);
        tick();
        tick();
        check("rst_alu_ready", bus.alu_ready, 1'b0);
        check("rst_mem_ready", bus.mem_ready, 1'b0);
        check("rst_rf_we", bus.rf_reg_write, 1'b0);
        check("rst_mask", bus.pending_mask, '0);
        rst = 1'b0;
        drive_alu(1'b0, '0, '0);
        tick();
        check("post_rst_alu_ready", bus.alu_ready, 1'b1);
        check("post_rst_mem_ready", bus.mem_ready, 1'b1);
        check("post_rst_no_write", bus.rf_reg_write, 1'b0);

        // Single uncontended ALU write
        drive_alu(1'b1, REG_ADDR_W'(5), 32'hDEAD_BEEF);
        tick();
        drive_alu(1'b0, '0, '0);
        check("single_n1_mask5", bus.pending_mask[5], 1'b1);
        check("single_n1_we", bus.rf_reg_write, 1'b0);
        tick();
        check("single_n2_we", bus.rf_reg_write, 1'b1);
        check("single_n2_dest", bus.rf_dest, 64'd5);
        check("single_n2_data", bus.rf_write_data, 64'hDEAD_BEEF);
        check("single_n2_mask5", bus.pending_mask[5], 1'b1);
        tick();
        check("single_n3_we", bus.rf_reg_write, 1'b0);
        check("single_n3_mask5", bus.pending_mask[5], 1'b0);

        // Load to x0 is accepted and dropped
        drive_mem(1'b1, '0, 32'h1234_5678);
        #1;
        check("x0_mem_ready_pre", bus.mem_ready, 1'b1);
        tick();
        drive_mem(1'b0, '0, '0);
        check("x0_mem_ready_post", bus.mem_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("x0_no_write", bus.rf_reg_write, 1'b0);
            check("x0_mask", bus.pending_mask, '0);
        end

        // Contention: both sources valid every cycle, ALU dests 1..15, mem 16..31
        alu_in  = 0;
        alu_out = 0;
        for (int c = 0; c < 16; c++) begin
            if (!bus.alu_valid || alu_acc)
                drive_alu(1'b1, REG_ADDR_W'($urandom_range(1, 15)), $urandom());
            if (!bus.mem_valid || mem_acc)
                drive_mem(1'b1, REG_ADDR_W'($urandom_range(16, 31)), $urandom());
            tick();
            if (alu_acc) alu_in++;
            if (bus.rf_reg_write === 1'b1) begin
                src_seq.push_back((bus.rf_dest >= REG_ADDR_W'(16)) ? 1 : 0);
                if (bus.rf_dest < REG_ADDR_W'(16)) alu_out++;
            end
        end
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b0, '0, '0);
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.rf_reg_write === 1'b1 && bus.rf_dest < REG_ADDR_W'(16)) alu_out++;
        end
        check("contention_write_count", src_seq.size() >= 12, 1'b1);
        for (int k = 0; k < src_seq.size() && k < 12; k++)
            check("contention_grant_order", src_seq[k], ((k % 4) == 3) ? 0 : 1);
        check("alu_all_written", alu_out, alu_in);

        // Backpressure: mem keeps winning while the ALU queue fills
        for (int c = 0; c < 3; c++) begin
            if (!bus.mem_valid || mem_acc)
                drive_mem(1'b1, REG_ADDR_W'($urandom_range(16, 31)), $urandom());
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            if (!bus.alu_valid || alu_acc)
                drive_alu(1'b1, REG_ADDR_W'($urandom_range(1, 15)), $urandom());
            if (!bus.mem_valid || mem_acc)
                drive_mem(1'b1, REG_ADDR_W'($urandom_range(16, 31)), $urandom());
            tick();
            check("backpressure_alu_ready", bus.alu_ready, bp_exp[k]);
        end
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b0, '0, '0);
        for (int c = 0; c < 8; c++) tick();

        // Reset in the middle of queued and presented writes
        drive_alu(1'b1, REG_ADDR_W'(3), 32'hA000_0003);
        drive_mem(1'b1, REG_ADDR_W'(20), 32'hB000_0014);
        tick();
        drive_alu(1'b1, REG_ADDR_W'(4), 32'hA000_0004);
        drive_mem(1'b1, REG_ADDR_W'(21), 32'hB000_0015);
        tick();
        check("midrst_mask_before", bus.pending_mask, 64'h0030_0018);
        rst = 1'b1;
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b0, '0, '0);
        #1;
        check("midrst_alu_ready", bus.alu_ready, 1'b0);
        check("midrst_mem_ready", bus.mem_ready, 1'b0);
        tick();
        rst = 1'b0;
        check("midrst_we", bus.rf_reg_write, 1'b0);
        check("midrst_mask", bus.pending_mask, '0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("midrst_no_stale_write", bus.rf_reg_write, 1'b0);
        end

        // Randomized traffic, including x0 destinations and stalls
        acc_cnt = 0;
        wr_cnt  = 0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.alu_valid || alu_acc)
                drive_alu($urandom_range(0, 99) < 60,
                          ($urandom_range(0, 7) == 0) ? '0 : REG_ADDR_W'($urandom_range(1, 31)),
                          $urandom());
            if (!bus.mem_valid || mem_acc)
                drive_mem($urandom_range(0, 99) < 50,
                          ($urandom_range(0, 7) == 0) ? '0 : REG_ADDR_W'($urandom_range(1, 31)),
                          $urandom());
            tick();
        end
        drive_alu(1'b0, '0, '0);
        drive_mem(1'b0, '0, '0);
        for (int c = 0; c < 10; c++) tick();
        check("random_total_writes", wr_cnt, acc_cnt);
        check("random_drained_mask", bus.pending_mask, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (reg_write / dest / write_data) between two writeback sources: the ALU and the load unit (mem).
- Each source has a small queue.
- Grants follow a fixed mem-first priority with an anti-starvation override for the ALU.
- Exports a pending-write mask so issue logic can stall on registers with queued writes.
- Sits between execute/memory stages and reg_file.

Parameters:
- XLEN, 32, data width of writeback values
- REG_ADDR_W, 5, register address width (32 architectural registers)
- FIFO_DEPTH, 2, entries per source queue (power of two, ≥2)
- STARVE_LIMIT, 3, consecutive lost ALU arbitrations before the ALU is forced to win

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU queue can accept
- alu_dest  in  REG_ADDR_W  ALU destination register
- alu_data  in  XLEN  ALU result
- mem_valid  in  1  load writeback request
- mem_ready  out  1  load queue can accept
- mem_dest  in  REG_ADDR_W  load destination register
- mem_data  in  XLEN  load data
- rf_reg_write  out  1  write enable to reg_file
- rf_dest  out  REG_ADDR_W  write address to reg_file
- rf_write_data  out  XLEN  write data to reg_file
- pending_mask  out  2^REG_ADDR_W  bit d = a write to register d is queued or presented

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: while rst=1, and at the first edge after it:
  - queues emptied; starvation counter 0;
  - rf_reg_write=0, rf_dest=0, rf_write_data=0;
  - pending_mask=0; alu_ready=mem_ready=0.
  - Readies rise in the first cycle with rst=0.
- Accept rule: a transfer occurs when valid && ready at a rising edge.
  - ready = !rst && (queue count < FIFO_DEPTH), from registered count only.
  - There is no same-cycle bypass: a full queue that is dequeuing this cycle still shows ready=0.
- Destination x0: a transfer with dest==0 is accepted (handshake completes) and then discarded. It is never enqueued, never written and never appears in pending_mask.
- Arbitration runs each cycle on the queue heads:
  - Only mem non-empty → grant mem.
  - Only ALU non-empty → grant ALU.
  - Both non-empty → grant mem, unless starve_cnt == STARVE_LIMIT, in which case grant ALU.
- Starvation counter:
  - Increments when both heads are valid and mem is granted.
  - Clears when the ALU is granted or the ALU queue is empty.
  - Saturates at STARVE_LIMIT.
- Output register: the granted head is popped at the edge. rf_reg_write=1, rf_dest, rf_write_data are registered and held for exactly one cycle per grant. rf_reg_write=0 when nothing is granted.
- Latency: accept at edge N → entry visible at a queue head in cycle N+1 → rf_* asserted in cycle N+2 (uncontended). The reg_file write occurs at the end of cycle N+2.
- Throughput: one write per cycle total.
- Ordering:
  - FIFO order is preserved within each source.
  - No ordering across sources; the issue stage uses pending_mask to avoid WAW between sources.
- pending_mask is combinational from state: OR over all valid queue entries, plus the rf output register when rf_reg_write=1. Bit 0 is always 0.
- Simultaneous enqueue and dequeue on the same queue in one cycle is legal (count unchanged).
- Reset mid-operation: all queued and presented writes are discarded. No rf_reg_write pulse occurs due to pre-reset entries.

Decomposition:
- Package regfile_wb_pkg holds:
  - XLEN and REG_ADDR_W defaults;
  - NUM_REGS = 2^REG_ADDR_W;
  - typedef wb_entry_t {dest, data};
  - enum wb_src_e {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_MEM} for grant encoding.
- Sub-module wb_fifo (parameterised synchronous FIFO of wb_entry_t):
  - outputs count, head, and per-entry valid/dest vectors for mask generation;
  - instantiated twice.

Test Plan:
- Reset: rst=1 for 2 cycles with alu_valid=1 → both readies 0, rf_reg_write 0, pending_mask 0. Cycle after rst falls: readies 1, no write emitted.
- Single write: ALU dest=5, data=0xDEADBEEF accepted at edge N → rf_reg_write=1, rf_dest=5, rf_write_data=0xDEADBEEF in cycle N+2 only. pending_mask[5]=1 in cycles N+1..N+2 and 0 at N+3.
- x0 drop: mem_valid dest=0, data=0x12345678 → mem_ready stays 1, rf_reg_write never asserts, pending_mask stays 0.
- Contention/starvation: both sources valid every cycle with distinct dests, STARVE_LIMIT=3 → grant sequence mem,mem,mem,alu repeating. Every ALU entry is eventually written.
- Backpressure: hold mem_valid=1 with the ALU idle; block draining by keeping mem granted while ALU queue fills (alu_valid=1, mem always winning) → alu_ready=0 after 2 accepts; it rises again the cycle after the first ALU pop.
- Reset mid-operation: 2 entries queued per source, assert rst for one cycle → next cycle rf_reg_write=0, pending_mask=0; no write from the old entries appears in the following 5 cycles.
